// File: rtl/instr_encoder.sv
// RV32I instruction encoder: turns field-level requests into 32-bit words and
// queues them in a 4-entry FIFO. Optional illegal-request filter: INSTR_ENC_ILLEGAL_CHECK_EN.
module instr_encoder (
  input  logic        clk,
  input  logic        reset,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic [2:0]  req_class,
  input  logic [2:0]  req_func3,
  input  logic        req_func7b5,
  input  logic [4:0]  req_rd,
  input  logic [4:0]  req_rs1,
  input  logic [4:0]  req_rs2,
  input  logic [11:0] req_imm,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] out_instr,
  output logic [2:0]  count,
  output logic        out_err
);

  localparam logic [6:0]  OP_R      = 7'b0110011;
  localparam logic [6:0]  OP_I      = 7'b0010011;
  localparam logic [6:0]  OP_LOAD   = 7'b0000011;
  localparam logic [6:0]  OP_STORE  = 7'b0100011;
  localparam logic [6:0]  OP_BRANCH = 7'b1100011;
  localparam logic [31:0] NOP_WORD  = 32'h0000_0013;

  logic [31:0] enc_word;
  logic [31:0] mem [4];
  logic [1:0]  wr_ptr;
  logic [1:0]  rd_ptr;
  logic        accept;
  logic        pop;
  logic        wr_en;

  always_comb begin
    enc_word = NOP_WORD;
    case (req_class)
      3'd0: enc_word = {(req_func7b5 ? 7'b0100000 : 7'b0000000), req_rs2, req_rs1,
                        req_func3, req_rd, OP_R};
      3'd1: begin
        // shift-immediates carry the SRAI select in the upper funct7 bits
        if (req_func3 == 3'b001 || req_func3 == 3'b101)
          enc_word = {1'b0, req_func7b5, 5'b00000, req_imm[4:0], req_rs1,
                      req_func3, req_rd, OP_I};
        else
          enc_word = {req_imm, req_rs1, req_func3, req_rd, OP_I};
      end
      3'd2: enc_word = {req_imm, req_rs1, req_func3, req_rd, OP_LOAD};
      3'd3: enc_word = {req_imm[11:5], req_rs2, req_rs1, req_func3, req_imm[4:0], OP_STORE};
      3'd4: enc_word = {req_imm[11], req_imm[9:4], req_rs2, req_rs1, req_func3,
                        req_imm[3:0], req_imm[10], OP_BRANCH};
      default: enc_word = NOP_WORD;
    endcase
  end

  // Ready is forced low while reset is held so nothing is taken during reset.
  assign req_ready = !reset && (count < 3'd4);
  assign out_valid = (count != 3'd0);
  assign accept    = req_valid && req_ready;
  assign pop       = out_valid && out_ready;
  assign out_instr = out_valid ? mem[rd_ptr] : 32'h0000_0000;

`ifdef INSTR_ENC_ILLEGAL_CHECK_EN
  logic illegal;

  always_comb begin
    illegal = 1'b0;
    case (req_class)
      3'd2:    illegal = (req_func3 == 3'b011) || (req_func3 == 3'b110) || (req_func3 == 3'b111);
      3'd3:    illegal = (req_func3 >= 3'b011);
      3'd4:    illegal = (req_func3 == 3'b010) || (req_func3 == 3'b011);
      3'd5,
      3'd6,
      3'd7:    illegal = 1'b1;
      default: illegal = 1'b0;
    endcase
  end

  // Illegal requests complete the handshake but never reach the queue.
  assign wr_en = accept && !illegal;

  always_ff @(posedge clk or posedge reset) begin
    if (reset)
      out_err <= 1'b0;
    else if (accept && illegal)
      out_err <= 1'b1;
  end
`else
  assign wr_en   = accept;
  assign out_err = 1'b0;
`endif

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      count  <= 3'd0;
      wr_ptr <= 2'd0;
      rd_ptr <= 2'd0;
    end else begin
      if (wr_en)
        wr_ptr <= wr_ptr + 2'd1;
      if (pop)
        rd_ptr <= rd_ptr + 2'd1;
      case ({wr_en, pop})
        2'b10:   count <= count + 3'd1;
        2'b01:   count <= count - 3'd1;
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (wr_en)
      mem[wr_ptr] <= enc_word;
  end

endmodule

// File: tb/tb_instr_encoder.sv
// Directed bench for instr_encoder: encodings, FIFO order/backpressure, async reset,
// and the INSTR_ENC_ILLEGAL_CHECK_EN behaviour for whichever build is compiled.
module tb_instr_encoder;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        req_valid = 1'b0;
  logic        req_ready;
  logic [2:0]  req_class = '0;
  logic [2:0]  req_func3 = '0;
  logic        req_func7b5 = 1'b0;
  logic [4:0]  req_rd = '0;
  logic [4:0]  req_rs1 = '0;
  logic [4:0]  req_rs2 = '0;
  logic [11:0] req_imm = '0;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic [31:0] out_instr;
  logic [2:0]  count;
  logic        out_err;

  int checks = 0;
  int errors = 0;

  instr_encoder dut (
    .clk(clk), .reset(reset),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_class(req_class), .req_func3(req_func3), .req_func7b5(req_func7b5),
    .req_rd(req_rd), .req_rs1(req_rs1), .req_rs2(req_rs2), .req_imm(req_imm),
    .out_valid(out_valid), .out_ready(out_ready), .out_instr(out_instr),
    .count(count), .out_err(out_err)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic set_req(input logic [2:0] cls, input logic [2:0] f3, input logic f7b5,
                         input logic [4:0] rd, input logic [4:0] rs1, input logic [4:0] rs2,
                         input logic [11:0] imm);
    req_valid   = 1'b1;
    req_class   = cls;
    req_func3   = f3;
    req_func7b5 = f7b5;
    req_rd      = rd;
    req_rs1     = rs1;
    req_rs2     = rs2;
    req_imm     = imm;
  endtask

  initial begin
    #1 reset = 1'b1;
    #1;
    check("rst_count", 32'(count), 32'd0);
    check("rst_out_valid", 32'(out_valid), 32'd0);
    check("rst_req_ready", 32'(req_ready), 32'd0);
    check("rst_out_instr", out_instr, 32'h0000_0000);
    check("rst_out_err", 32'(out_err), 32'd0);
    tick();
    tick();
    reset = 1'b0;
    #1;
    check("post_rst_req_ready", 32'(req_ready), 32'd1);

    // R ADD x1,x2,x3
    set_req(3'd0, 3'd0, 1'b0, 5'd1, 5'd2, 5'd3, 12'h000);
    tick();
    req_valid = 1'b0;
    check("add_valid", 32'(out_valid), 32'd1);
    check("add_word", out_instr, 32'h0031_00B3);
    check("add_count", 32'(count), 32'd1);
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    check("add_popped_count", 32'(count), 32'd0);
    check("add_popped_valid", 32'(out_valid), 32'd0);

    // ADDI x5,x0,-1 then SW x2,8(x1)
    set_req(3'd1, 3'd0, 1'b0, 5'd5, 5'd0, 5'd0, 12'hFFF);
    tick();
    set_req(3'd3, 3'd2, 1'b0, 5'd0, 5'd1, 5'd2, 12'd8);
    tick();
    req_valid = 1'b0;
    check("addi_sw_count", 32'(count), 32'd2);
    check("addi_word", out_instr, 32'hFFF0_0293);
    out_ready = 1'b1;
    tick();
    check("sw_word", out_instr, 32'h0020_A423);
    tick();
    out_ready = 1'b0;
    check("addi_sw_drained", 32'(count), 32'd0);

    // BEQ x1,x2,+8
    set_req(3'd4, 3'd0, 1'b0, 5'd0, 5'd1, 5'd2, 12'd4);
    tick();
    req_valid = 1'b0;
    check("beq_word", out_instr, 32'h0020_8463);
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;

    // Fill: SUB, SRAI (junk in imm[11:5]), LW, BNE -4, then a fifth ADD held
    set_req(3'd0, 3'd0, 1'b1, 5'd1, 5'd2, 5'd3, 12'h000);
    tick();
    set_req(3'd1, 3'd5, 1'b1, 5'd1, 5'd2, 5'd0, 12'hFE3);
    tick();
    set_req(3'd2, 3'd2, 1'b0, 5'd3, 5'd4, 5'd0, 12'h010);
    tick();
    set_req(3'd4, 3'd1, 1'b0, 5'd0, 5'd1, 5'd0, 12'hFFE);
    tick();
    set_req(3'd0, 3'd0, 1'b0, 5'd1, 5'd2, 5'd3, 12'h000);
    check("full_count", 32'(count), 32'd4);
    check("full_req_ready", 32'(req_ready), 32'd0);
    tick();
    check("full_hold_count", 32'(count), 32'd4);
    check("full_hold_word", out_instr, 32'h4031_00B3);
    out_ready = 1'b1;
    tick();
    check("pop_from_full_count", 32'(count), 32'd3);
    check("pop_from_full_ready", 32'(req_ready), 32'd1);
    check("srai_word", out_instr, 32'h4031_5093);
    tick();
    req_valid = 1'b0;
    check("push_pop_count", 32'(count), 32'd3);
    check("lw_word", out_instr, 32'h0102_2183);
    tick();
    check("bne_word", out_instr, 32'hFE00_9EE3);
    check("bne_count", 32'(count), 32'd2);
    tick();
    check("wrapped_add_word", out_instr, 32'h0031_00B3);
    tick();
    out_ready = 1'b0;
    check("drain_count", 32'(count), 32'd0);

    // Asynchronous reset with three entries queued
    set_req(3'd1, 3'd0, 1'b0, 5'd7, 5'd7, 5'd0, 12'h001);
    tick();
    tick();
    tick();
    req_valid = 1'b0;
    check("pre_rst_count", 32'(count), 32'd3);
    #2 reset = 1'b1;
    #1;
    check("async_rst_count", 32'(count), 32'd0);
    check("async_rst_valid", 32'(out_valid), 32'd0);
    check("async_rst_instr", out_instr, 32'h0000_0000);
    check("async_rst_ready", 32'(req_ready), 32'd0);
    #1 reset = 1'b0;
    tick();
    check("after_rst_ready", 32'(req_ready), 32'd1);
    check("after_rst_count", 32'(count), 32'd0);
    set_req(3'd0, 3'd0, 1'b0, 5'd1, 5'd2, 5'd3, 12'h000);
    tick();
    req_valid = 1'b0;
    check("after_rst_word", out_instr, 32'h0031_00B3);
    check("after_rst_push_count", 32'(count), 32'd1);
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;

`ifdef INSTR_ENC_ILLEGAL_CHECK_EN
    set_req(3'd2, 3'd7, 1'b0, 5'd1, 5'd2, 5'd0, 12'h000);
    tick();
    req_valid = 1'b0;
    check("illegal_count", 32'(count), 32'd0);
    check("illegal_err", 32'(out_err), 32'd1);
    set_req(3'd6, 3'd0, 1'b0, 5'd0, 5'd0, 5'd0, 12'h000);
    tick();
    req_valid = 1'b0;
    check("reserved_count", 32'(count), 32'd0);
    check("err_sticky", 32'(out_err), 32'd1);
`else
    set_req(3'd6, 3'd0, 1'b0, 5'd1, 5'd2, 5'd3, 12'hABC);
    tick();
    req_valid = 1'b0;
    check("reserved_nop", out_instr, 32'h0000_0013);
    check("reserved_count", 32'(count), 32'd1);
    check("no_err", 32'(out_err), 32'd0);
    set_req(3'd2, 3'd7, 1'b0, 5'd3, 5'd4, 5'd0, 12'h010);
    out_ready = 1'b1;
    tick();
    req_valid = 1'b0;
    check("unchecked_load_word", out_instr, 32'h0102_7183);
    check("unchecked_load_err", 32'(out_err), 32'd0);
    tick();
    out_ready = 1'b0;
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
